// File: rtl/sop_pkg.sv
// -----------------------------------------------------------------------------
// sop_pkg
// Shared definitions for the sum-of-products sweep unit:
//   - sop_state_t      : sweep controller state encoding (IDLE/SWEEP/DONE)
//   - SOP_DEFAULT_MASK : reset minterm mask for f = m(1,3,4,7), bit i = f(i)
// -----------------------------------------------------------------------------
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sop_state_t;

    localparam logic [7:0] SOP_DEFAULT_MASK = 8'b1001_1010;

endpackage

// File: rtl/sop_lut.sv
// -----------------------------------------------------------------------------
// sop_lut
// Combinational 2^N-to-1 minterm selector: returns mask[idx], i.e. the value
// of the programmed Boolean function at input combination idx.
// Ports:
//   mask : input,  2^N bits, truth table (bit i = f(i))
//   idx  : input,  N bits,   minterm index (idx[N-1] is the MSB variable)
//   sel  : output, 1 bit,    f(idx)
// -----------------------------------------------------------------------------
module sop_lut #(
    parameter int N = 3
) (
    input  logic [(1<<N)-1:0] mask,
    input  logic [N-1:0]      idx,
    output logic              sel
);

    assign sel = mask[idx];

endmodule

// File: rtl/sop_sweep_unit.sv
// -----------------------------------------------------------------------------
// sop_sweep_unit
// Programmable N-input sum-of-products evaluator. The live path registers
// f(x_in) every cycle; the sweep path streams f(i) for i = 0..2^N-1 over a
// valid/ready interface and reports how many minterms evaluate to 1.
// Ports:
//   clk, reset           : clock (rising edge), async active-high reset
//   load, mask_in        : write a new truth table (accepted in IDLE only)
//   x_in, s              : live input vector and registered f(x_in)
//   start                : begin a sweep (accepted in IDLE only)
//   sw_valid, sw_ready   : sweep beat handshake
//   sw_idx, sw_out       : beat minterm index and f(sw_idx)
//   busy, done           : sweep in progress / one-cycle end-of-sweep pulse
//   ones_count           : number of 1-minterms found by the last sweep
// -----------------------------------------------------------------------------
module sop_sweep_unit
    import sop_pkg::*;
#(
    parameter int                N         = 3,
    parameter logic [(1<<N)-1:0] MASK_INIT = SOP_DEFAULT_MASK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [(1<<N)-1:0] mask_in,
    input  logic [N-1:0]      x_in,
    output logic              s,
    input  logic              start,
    output logic              sw_valid,
    input  logic              sw_ready,
    output logic [N-1:0]      sw_idx,
    output logic              sw_out,
    output logic              busy,
    output logic              done,
    output logic [N:0]        ones_count
);

    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};
    localparam logic [N-1:0] IDX_ONE  = N'(1);

    sop_state_t        state_r;
    logic [(1<<N)-1:0] mask_r;
    logic [N-1:0]      idx_r;
    logic [N:0]        acc_r;
    logic [N:0]        ones_count_r;
    logic              s_r;
    logic              sw_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              live_bit_s;
    logic              sweep_bit_s;
    logic [N:0]        acc_next_s;

    sop_lut #(.N(N)) u_live_lut (
        .mask (mask_r),
        .idx  (x_in),
        .sel  (live_bit_s)
    );

    sop_lut #(.N(N)) u_sweep_lut (
        .mask (mask_r),
        .idx  (idx_r),
        .sel  (sweep_bit_s)
    );

    // Accumulator is one bit wider than idx so an all-ones mask counts 2^N.
    assign acc_next_s = acc_r + {{N{1'b0}}, sweep_bit_s};

    // Live evaluation register and sweep controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            mask_r       <= MASK_INIT;
            idx_r        <= {N{1'b0}};
            acc_r        <= {(N+1){1'b0}};
            ones_count_r <= {(N+1){1'b0}};
            s_r          <= 1'b0;
            sw_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            s_r <= live_bit_s;
            case (state_r)
                IDLE: begin
                    // A same-cycle load lands together with start, so the
                    // first beat already sees the new mask.
                    if (load) begin
                        mask_r <= mask_in;
                    end
                    if (start) begin
                        state_r    <= SWEEP;
                        idx_r      <= {N{1'b0}};
                        acc_r      <= {(N+1){1'b0}};
                        sw_valid_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                SWEEP: begin
                    // sw_valid is always high here, so sw_ready alone marks
                    // an accepted beat; the mask is frozen until IDLE.
                    if (sw_ready) begin
                        acc_r <= acc_next_s;
                        if (idx_r == IDX_LAST) begin
                            state_r      <= DONE;
                            ones_count_r <= acc_next_s;
                            sw_valid_r   <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    sw_valid_r <= 1'b0;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign s          = s_r;
    assign sw_valid   = sw_valid_r;
    assign sw_idx     = idx_r;
    assign sw_out     = sweep_bit_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign ones_count = ones_count_r;

endmodule

// File: doc/sop_sweep_unit.md
# sop_sweep_unit

Parametrised sum-of-products evaluator for N-input Boolean functions given as a programmable minterm mask. It evaluates the function on a live input vector with a one-cycle registered output. A sequential sweep mode enumerates all 2^N input combinations over a valid/ready stream and counts the minterms that evaluate to 1. The block sits in the combinational-logic lab datapath as the successor to the fixed 3-input SoP expressions, so a function's truth table can be produced and checked by hardware rather than hand-listed.

## Interface
- N, default 3: number of Boolean inputs, legal range 1..6.
- MASK_INIT, default 8'b1001_1010: reset minterm mask, with bit i = f(i). The default is m(1,3,4,7).
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- load, input, 1: write mask_in into the mask register. Accepted in IDLE only.
- mask_in, input, 2^N: new minterm mask.
- x_in, input, N: live input vector; x_in[N-1] is the most significant variable (x).
- s, output, 1: registered f(x_in).
- start, input, 1: begin a sweep. Accepted in IDLE only.
- sw_valid, output, 1: sweep beat valid.
- sw_ready, input, 1: consumer accepts the beat.
- sw_idx, output, N: minterm index of the current beat.
- sw_out, output, 1: f(sw_idx).
- busy, output, 1: high in SWEEP and DONE.
- done, output, 1: one-cycle pulse at sweep end.
- ones_count, output, N+1: number of minterms equal to 1 in the last sweep.

## Operation
- Reset values: mask = MASK_INIT, state = IDLE, s = 0, sw_valid = 0, sw_idx = 0, busy = 0, done = 0, ones_count = 0. sw_out equals mask[0].
- Live path: s <= mask[x_in] on every edge, in any state.
- States:
  - IDLE to SWEEP on start. idx is cleared and the count accumulator is cleared. ones_count keeps its old value until DONE.
  - SWEEP: sw_valid = 1, sw_idx = idx, sw_out = mask[idx].
    - On sw_valid & sw_ready, the accumulator adds sw_out.
    - If idx == 2^N-1, go to DONE; otherwise idx increments.
    - Without sw_ready, sw_idx and sw_out hold stable.
  - DONE: ones_count <= accumulator, done = 1, sw_valid = 0, then go to IDLE on the next edge.
- load and start in the same IDLE cycle: the mask updates on that edge. The sweep uses the new mask from its first beat.
- load, or start, during SWEEP/DONE is ignored. The mask is frozen for the whole sweep.
- Width rules:
  - The accumulator and ones_count are N+1 bits, so a count of 2^N never wraps.
  - idx is N bits; its terminal value is checked before incrementing, so no wrap-around beat is emitted.
- Reset asserted mid-sweep aborts immediately to reset values. No done pulse is produced and ones_count clears to 0.
- sw_ready while sw_valid = 0 has no effect.

## Timing
- Live evaluation latency: 1 edge from a change on x_in to s. A mask load is visible on s from the edge after the load edge.
- start sampled at edge k: sw_valid rises after edge k, carrying idx 0.
- With sw_ready held at 1: one beat per cycle, 2^N beats. Beat j is accepted at edge k+1+j.
- done is high for exactly one cycle after edge k+2^N, and ones_count is valid in that same cycle.
- busy falls, and a new start is accepted, one cycle after done.
- Each cycle with sw_ready = 0 adds exactly one cycle to the sweep.
- All outputs are driven from registers or from register-indexed mask bits. There is no combinational path from any input to an output.

## Structure
- A shared package `sop_pkg` holds:
  - the state encoding localparams: IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2;
  - the default mask constant for m(1,3,4,7).
- One sub-module, `sop_lut`: a combinational 2^N-to-1 minterm selector (mask, index in, bit out). It is instantiated twice, once for the live path and once for the sweep path.

## Test plan
- Live evaluation: after reset with N = 3 and the default mask, x_in steps through 0..7 one per cycle. s, lagging by one cycle, must read 0,1,0,1,1,0,0,1.
- Full-speed sweep: start with sw_ready = 1.
  - sw_idx must read 0..7 and sw_out must read 0,1,0,1,1,0,0,1.
  - done must pulse 9 cycles after start, with ones_count = 4.
- Load then sweep: load mask_in = 8'hFF with start in the same cycle.
  - Every sw_out must be 1.
  - ones_count must be 8, which checks that the count does not wrap at 2^N.
- Backpressure: sweep with sw_ready = 0 on beats 2 and 5 for 3 cycles each.
  - sw_idx and sw_out must hold while stalled.
  - done must pulse at cycle 15.
  - ones_count must be 4.
- Ignored requests: assert load with 8'h00, and start, during a sweep. The mask must remain 8'h9A and ones_count must be 4.
- Reset mid-sweep: assert reset at beat 4.
  - Outputs must return to reset values immediately, with no done pulse.
  - A fresh sweep afterwards must give ones_count = 4.
